// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution filter-set scheduler.
package conv_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_e;

    // Number of filter sets processed per layer.
    function automatic int sets_of(input int k, input int n_eng);
        return k / n_eng;
    endfunction

endpackage

// File: rtl/conv_filter_scheduler_if.sv
// Engine-control and output-slice handshake bundle between the scheduler and the datapath.
interface conv_filter_scheduler_if #(
    parameter int N_ENG = 2,
    parameter int SET_W = 5
);
    logic             eng_reset;
    logic [SET_W-1:0] filter_set_idx;
    logic [N_ENG-1:0] eng_done;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output eng_reset, filter_set_idx, out_valid,
        input  eng_done, out_ready
    );

    modport slave (
        input  eng_reset, filter_set_idx, out_valid,
        output eng_done, out_ready
    );
endinterface

// File: rtl/conv_done_tracker.sv
// Accumulates per-engine completion for one filter set and counts RUN cycles for the timeout guard.
module conv_done_tracker #(
    parameter int N_ENG   = 2,
    parameter int LAT_MAX = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [N_ENG-1:0] eng_done,
    output logic             all_done,
    output logic             timeout
);
    localparam int CNT_W = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT_MAX - 1);

    logic [N_ENG-1:0] done_mask_q, done_mask_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_mask_q <= '0;
            run_cnt_q   <= '0;
        end else begin
            done_mask_q <= done_mask_d;
            run_cnt_q   <= run_cnt_d;
        end
    end

    // A level held high simply re-ORs the same bit, so each engine counts once.
    always_comb begin
        done_mask_d = done_mask_q;
        run_cnt_d   = run_cnt_q;
        if (clear) begin
            done_mask_d = '0;
            run_cnt_d   = '0;
        end else if (enable) begin
            done_mask_d = done_mask_q | eng_done;
            run_cnt_d   = run_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        all_done = &(done_mask_q | eng_done);
        timeout  = (run_cnt_q == CNT_LAST);
    end

endmodule

// File: rtl/conv_filter_scheduler.sv
// Steps the convolution engines through K filters in sets of N_ENG, with completion tracking and a RUN timeout.
//   state | meaning
//   IDLE  | engines in reset, waiting for start
//   LOAD  | engines in reset for one cycle while the set index settles
//   RUN   | engines running, collecting eng_done
//   DRAIN | slice presented to writer, waiting for out_ready
//   FIN   | one-cycle done pulse, engines back in reset
module conv_filter_scheduler
    import conv_pkg::*;
#(
    parameter int K       = 64,
    parameter int N_ENG   = 2,
    parameter int LAT_MAX = 4096,
    parameter int SET_W   = ((K / N_ENG) > 1) ? $clog2(K / N_ENG) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    output logic timeout_err,
    conv_filter_scheduler_if.master eng_if
);
    localparam int N_SETS = sets_of(K, N_ENG);
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(N_SETS - 1);

    state_e           state_q, state_d;
    logic [SET_W-1:0] filter_set_idx_q, filter_set_idx_d;
    logic             timeout_err_q, timeout_err_d;

    logic trk_clear;
    logic trk_enable;
    logic all_done;
    logic run_timeout;

    conv_done_tracker #(
        .N_ENG   (N_ENG),
        .LAT_MAX (LAT_MAX)
    ) u_done_tracker (
        .clk      (clk),
        .reset    (reset),
        .clear    (trk_clear),
        .enable   (trk_enable),
        .eng_done (eng_if.eng_done),
        .all_done (all_done),
        .timeout  (run_timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            filter_set_idx_q <= '0;
            timeout_err_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            filter_set_idx_q <= filter_set_idx_d;
            timeout_err_q    <= timeout_err_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        filter_set_idx_d = filter_set_idx_q;
        timeout_err_d    = timeout_err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d          = LOAD;
                    filter_set_idx_d = '0;
                    timeout_err_d    = 1'b0;
                end
            end
            LOAD: state_d = RUN;
            RUN: begin
                // Completion wins over timeout when both land on the same cycle.
                if (all_done) begin
                    state_d = DRAIN;
                end else if (run_timeout) begin
                    timeout_err_d = 1'b1;
                    state_d       = FIN;
                end
            end
            DRAIN: begin
                if (eng_if.out_ready) begin
                    if (filter_set_idx_q == LAST_SET) begin
                        state_d = FIN;
                    end else begin
                        filter_set_idx_d = filter_set_idx_q + SET_W'(1);
                        state_d          = LOAD;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy                  = (state_q != IDLE);
        done                  = (state_q == FIN);
        timeout_err           = timeout_err_q;
        eng_if.eng_reset      = (state_q == IDLE) || (state_q == LOAD) || (state_q == FIN);
        eng_if.out_valid      = (state_q == DRAIN);
        eng_if.filter_set_idx = filter_set_idx_q;
        trk_clear             = (state_q == LOAD);
        trk_enable            = (state_q == RUN);
    end

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// Directed bench for conv_filter_scheduler with K=4, N_ENG=2, LAT_MAX=16.
module tb_conv_filter_scheduler;

    localparam int K       = 4;
    localparam int N_ENG   = 2;
    localparam int LAT_MAX = 16;
    localparam int SET_W   = 1;

    logic clk;
    logic reset;
    logic start;
    logic busy;
    logic done;
    logic timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    conv_filter_scheduler_if #(.N_ENG(N_ENG), .SET_W(SET_W)) ifc ();

    conv_filter_scheduler #(
        .K       (K),
        .N_ENG   (N_ENG),
        .LAT_MAX (LAT_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .eng_if      (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [1:0] ed;
        logic       rdy;
        logic       busy;
        logic       done;
        logic       er;
        logic       idx;
        logic       ov;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic [1:0] e, input logic r,
                                input logic b, input logic d, input logic er,
                                input logic ix, input logic ov, input logic to);
        vec_t v;
        v.start = s; v.ed = e; v.rdy = r;
        v.busy = b; v.done = d; v.er = er; v.idx = ix; v.ov = ov; v.to = to;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic b, input logic d, input logic er,
                           input logic ix, input logic ov, input logic to);
        chk({tag, " busy"}, 32'(busy), 32'(b));
        chk({tag, " done"}, 32'(done), 32'(d));
        chk({tag, " eng_reset"}, 32'(ifc.eng_reset), 32'(er));
        chk({tag, " idx"}, 32'(ifc.filter_set_idx), 32'(ix));
        chk({tag, " out_valid"}, 32'(ifc.out_valid), 32'(ov));
        chk({tag, " timeout_err"}, 32'(timeout_err), 32'(to));
    endtask

    // Drive inputs on the falling edge, then sample just after the next rising edge.
    task automatic step(input logic s, input logic [1:0] e, input logic r);
        @(negedge clk);
        start = s;
        ifc.eng_done = e;
        ifc.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, vrun, vmax, done_cnt, done_at, runs, rc;
        logic [1:0] ed;
        logic idx_seen[2];
        logic saw_done;

        reset = 1'b1;
        start = 1'b0;
        ifc.eng_done = '0;
        ifc.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Minimum latency with engines pre-done, starts while busy ignored, then backpressure.
        tbl.push_back(mk(1, 3, 1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 3, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 3, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 3, 1, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 3, 1, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 3, 1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 3, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 1, 0, 0, 0, 1, 0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 3, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 2, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 2, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].start, tbl[i].ed, tbl[i].rdy);
            chk_all($sformatf("vec%0d", i), tbl[i].busy, tbl[i].done, tbl[i].er,
                    tbl[i].idx, tbl[i].ov, tbl[i].to);
        end

        // Engines finishing on different RUN cycles (2 and 7).
        step(1, 0, 1);
        for (int c = 1; c <= 7; c++) begin
            ed = ((c >= 2) ? 2'b01 : 2'b00) | ((c >= 7) ? 2'b10 : 2'b00);
            step(0, ed, 1);
            chk($sformatf("skew c%0d eng_reset", c), 32'(ifc.eng_reset), 32'(0));
            chk($sformatf("skew c%0d out_valid", c), 32'(ifc.out_valid), (c == 7) ? 32'd1 : 32'd0);
        end
        step(0, 0, 1);
        chk_all("skew load1", 1, 0, 1, 1, 0, 0);
        step(0, 3, 1);
        step(0, 3, 1);
        step(0, 0, 1);
        chk_all("skew fin", 1, 1, 1, 1, 0, 0);
        step(0, 0, 1);
        chk_all("skew idle", 0, 0, 1, 1, 0, 0);

        // Engines report done 5 cycles into each RUN; observe the whole layer.
        pulses = 0; vrun = 0; vmax = 0; done_cnt = 0; done_at = -1; rc = 0;
        idx_seen[0] = 1'bx; idx_seen[1] = 1'bx;
        step(1, 0, 1);
        for (int i = 0; i < 60; i++) begin
            if (busy && !ifc.eng_reset && !ifc.out_valid) rc++;
            else rc = 0;
            step(0, (rc >= 5) ? 2'b11 : 2'b00, 1);
            if (ifc.out_valid) begin
                if (pulses < 2) idx_seen[pulses] = ifc.filter_set_idx;
                pulses++;
                vrun++;
                if (vrun > vmax) vmax = vrun;
            end else begin
                vrun = 0;
            end
            if (done) begin
                done_cnt++;
                done_at = i;
                chk("run5 busy at done", 32'(busy), 32'(1));
            end
            if (done_at >= 0 && !done) begin
                chk("run5 busy after fin", 32'(busy), 32'(0));
                break;
            end
        end
        chk("run5 valid pulses", 32'(pulses), 32'(2));
        chk("run5 idx first", 32'(idx_seen[0]), 32'(0));
        chk("run5 idx second", 32'(idx_seen[1]), 32'(1));
        chk("run5 valid width", 32'(vmax), 32'(1));
        chk("run5 done count", 32'(done_cnt), 32'(1));
        chk("run5 done cycle", 32'(done_at), 32'(13));
        chk("run5 timeout_err", 32'(timeout_err), 32'(0));

        // Timeout with engines never finishing.
        runs = 0; saw_done = 1'b0;
        step(1, 0, 1);
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 1);
            if (busy && !ifc.eng_reset && !ifc.out_valid) runs++;
            if (done) begin
                saw_done = 1'b1;
                chk("tmo err at fin", 32'(timeout_err), 32'(1));
                break;
            end
        end
        chk("tmo done seen", 32'(saw_done), 32'(1));
        chk("tmo run cycles", 32'(runs), 32'(LAT_MAX));
        step(0, 0, 1);
        chk_all("tmo idle", 0, 0, 1, 0, 0, 1);
        step(1, 0, 1);
        chk_all("tmo restart", 1, 0, 1, 0, 0, 0);

        // Asynchronous reset during RUN of set 1.
        step(0, 3, 1);
        step(0, 3, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        chk_all("pre-reset run1", 1, 0, 0, 1, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async reset", 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(0, 3, 1);
            if (done || busy) saw_done = 1'b1;
        end
        chk("post-reset quiet", 32'(saw_done), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
